// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table: 2-bit counters, tag and target per entry, registered lookup.
// Defining BP_GSHARE_EN XORs a global history register into the table index (gshare).
module branch_predictor_bht #(
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned TAG_BITS  = 8,
  parameter logic [1:0]  CNT_ALLOC = 2'b10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lk_valid,
  input  logic [31:0]         lk_pc,
  output logic                pred_valid,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic                ready,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target
`ifdef BP_GSHARE_EN
  ,
  output logic [IDX_BITS-1:0] pred_ghr,
  input  logic [IDX_BITS-1:0] upd_ghr
`endif
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam int unsigned TAG_LSB = IDX_BITS + 2;
  localparam int unsigned TAG_MSB = IDX_BITS + TAG_BITS + 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : (c + 2'b01);
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : (c - 2'b01);
  endfunction

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] clr_ptr_q, clr_ptr_d;
  logic                clear_en_s;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [1:0]          cnt_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx_s, upd_idx_s;
  logic [TAG_BITS-1:0] lk_tag_s, upd_tag_s;
  logic                upd_hit_s, tbl_we_s;
  logic [1:0]          new_cnt_s;
  logic [31:0]         new_target_s;

  logic                e_valid_s;
  logic [TAG_BITS-1:0] e_tag_s;
  logic [1:0]          e_cnt_s;
  logic [31:0]         e_target_s;
  logic                lk_hit_s, lk_taken_s;
  logic [31:0]         lk_seq_s;

  logic                pred_valid_q, pred_valid_d;
  logic                pred_hit_q, pred_hit_d;
  logic                pred_taken_q, pred_taken_d;
  logic [31:0]         pred_target_q, pred_target_d;
  logic                ready_q, ready_d;

  logic                unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[31:TAG_MSB+1], upd_pc[1:0]};

  assign lk_tag_s  = lk_pc[TAG_MSB:TAG_LSB];
  assign upd_tag_s = upd_pc[TAG_MSB:TAG_LSB];
  assign lk_seq_s  = lk_pc + 32'd4;

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q, ghr_d;
  logic [IDX_BITS-1:0] pred_ghr_q, pred_ghr_d;

  assign lk_idx_s  = lk_pc[IDX_BITS+1:2] ^ ghr_q;
  assign upd_idx_s = upd_pc[IDX_BITS+1:2] ^ upd_ghr;
  assign pred_ghr  = pred_ghr_q;

  // History: held at zero while the table clears, then shifts in every resolved outcome.
  always_comb begin
    ghr_d = ghr_q;
    if (state_q == ST_INIT) begin
      ghr_d = {IDX_BITS{1'b0}};
    end else if (upd_valid) begin
      ghr_d = {ghr_q[IDX_BITS-2:0], upd_taken};
    end else begin
      ghr_d = ghr_q;
    end
  end

  // History register and the history value reported alongside each prediction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q      <= {IDX_BITS{1'b0}};
      pred_ghr_q <= {IDX_BITS{1'b0}};
    end else begin
      ghr_q      <= ghr_d;
      pred_ghr_q <= pred_ghr_d;
    end
  end

  // Reported history holds between lookups like the other prediction fields.
  always_comb begin
    pred_ghr_d = pred_ghr_q;
    if (lk_valid) begin
      pred_ghr_d = ghr_q;
    end else begin
      pred_ghr_d = pred_ghr_q;
    end
  end
`else
  assign lk_idx_s  = lk_pc[IDX_BITS+1:2];
  assign upd_idx_s = upd_pc[IDX_BITS+1:2];
`endif

  // Init sweep: one valid bit cleared per cycle, then RUN until the next reset.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clear_en_s = 1'b0;
    case (state_q)
      ST_INIT: begin
        clear_en_s = 1'b1;
        clr_ptr_d  = clr_ptr_q + {{(IDX_BITS-1){1'b0}}, 1'b1};
        if (clr_ptr_q == {IDX_BITS{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = ST_INIT;
        clr_ptr_d = {IDX_BITS{1'b0}};
      end
    endcase
  end

  // FSM state and clear pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= {IDX_BITS{1'b0}};
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);

  // Training: counter/target refresh on hit, allocation on a taken miss, nothing otherwise.
  always_comb begin
    tbl_we_s     = 1'b0;
    new_cnt_s    = cnt_q[upd_idx_s];
    new_target_s = target_q[upd_idx_s];
    if ((state_q == ST_RUN) && upd_valid) begin
      if (upd_hit_s) begin
        tbl_we_s = 1'b1;
        if (upd_taken) begin
          new_cnt_s    = cnt_inc(cnt_q[upd_idx_s]);
          new_target_s = upd_target;
        end else begin
          new_cnt_s = cnt_dec(cnt_q[upd_idx_s]);
        end
      end else if (upd_taken) begin
        tbl_we_s     = 1'b1;
        new_cnt_s    = CNT_ALLOC;
        new_target_s = upd_target;
      end else begin
        tbl_we_s = 1'b0;
      end
    end else begin
      tbl_we_s = 1'b0;
    end
  end

  // Table storage; validity comes from the init sweep, so no reset on the arrays.
  always_ff @(posedge clk) begin
    if (!rst && clear_en_s) begin
      valid_q[clr_ptr_q] <= 1'b0;
    end else if (!rst && tbl_we_s) begin
      valid_q[upd_idx_s]  <= 1'b1;
      tag_q[upd_idx_s]    <= upd_tag_s;
      cnt_q[upd_idx_s]    <= new_cnt_s;
      target_q[upd_idx_s] <= new_target_s;
    end
  end

  // Write-first view of the looked-up entry: a same-cycle write to that index wins.
  always_comb begin
    e_valid_s  = 1'b0;
    e_tag_s    = {TAG_BITS{1'b0}};
    e_cnt_s    = 2'b00;
    e_target_s = 32'd0;
    if (tbl_we_s && (upd_idx_s == lk_idx_s)) begin
      e_valid_s  = 1'b1;
      e_tag_s    = upd_tag_s;
      e_cnt_s    = new_cnt_s;
      e_target_s = new_target_s;
    end else begin
      e_valid_s  = valid_q[lk_idx_s];
      e_tag_s    = tag_q[lk_idx_s];
      e_cnt_s    = cnt_q[lk_idx_s];
      e_target_s = target_q[lk_idx_s];
    end
  end

  assign lk_hit_s   = (state_q == ST_RUN) && e_valid_s && (e_tag_s == lk_tag_s);
  assign lk_taken_s = lk_hit_s && e_cnt_s[1];

  // Prediction fields update only on a lookup; pred_valid follows lk_valid every cycle.
  always_comb begin
    pred_valid_d  = lk_valid;
    pred_hit_d    = pred_hit_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    ready_d       = (state_d == ST_RUN);
    if (lk_valid) begin
      pred_hit_d    = lk_hit_s;
      pred_taken_d  = lk_taken_s;
      pred_target_d = lk_taken_s ? e_target_s : lk_seq_s;
    end else begin
      pred_hit_d    = pred_hit_q;
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'd0;
      ready_q       <= 1'b0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      ready_q       <= ready_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign ready       = ready_q;

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Dynamic branch predictor for the dynamic pipeline; successor to the IF/ID combinational taken/not-taken resolver.
- IF presents a PC and gets a registered prediction (taken, target, hit) one cycle later.
- EX/MEM reports the resolved outcome back to train the table.
- Table is direct-mapped: 2^IDX_BITS entries, each holding a valid bit, tag, 2-bit saturating counter and 32-bit target.

Parameters:
- IDX_BITS, 6, log2 of entry count (64 entries).
- TAG_BITS, 8, tag width taken from PC above the index bits.
- CNT_ALLOC, 2'b10, counter value written when a new entry is allocated (weakly taken).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- lk_valid  in  1  lookup request this cycle.
- lk_pc  in  32  PC to predict.
- pred_valid  out  1  prediction outputs valid (one cycle after lk_valid).
- pred_hit  out  1  entry valid and tag matched.
- pred_taken  out  1  predicted taken (counter[1] on hit, else 0).
- pred_target  out  32  predicted next PC.
- ready  out  1  table initialised; updates accepted.
- upd_valid  in  1  resolved conditional branch or jump this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual target when taken.

Behaviour:
- Index = pc[IDX_BITS+1:2]. Tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Reset: all outputs 0, FSM to INIT, clear pointer to 0. rst asserted mid-operation restarts INIT from index 0 on the next edge.
- FSM INIT: clears one entry's valid bit per cycle; ready=0; upd_valid ignored.
  - Lookups still complete with pred_hit=0, pred_taken=0, pred_target=lk_pc+4.
  - After entry 2^IDX_BITS-1 is cleared, goes to RUN; ready=1. INIT lasts exactly 2^IDX_BITS cycles after rst deasserts.
- FSM RUN: stays in RUN until rst.
- Lookup, 1-cycle latency: registers lk_valid to pred_valid.
  - Hit: pred_taken=cnt[1]; pred_target = cnt[1] ? stored target : lk_pc+4.
  - Miss: not taken, pred_target=lk_pc+4.
  - Outputs hold their values while lk_valid=0, except pred_valid, which drops to 0.
- Update, RUN only, written at the clock edge:
  - Hit: counter saturating +1 if taken, -1 if not (bounds 00 and 11). Target overwritten if taken.
  - Miss and taken: allocate. valid=1, tag written, cnt=CNT_ALLOC, target=upd_target. Replaces any previous occupant.
  - Miss and not taken: no change.
- Simultaneous lookup and update to the same index in the same cycle: the lookup sees the post-update entry (write-first bypass).
- PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFFFFFC+4 = 0).

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - Adds a global history register ghr[IDX_BITS-1:0], reset to 0 and cleared during INIT.
  - In RUN, each upd_valid shifts in upd_taken at the LSB.
  - Lookup index = pc index XOR ghr. Adds output pred_ghr [IDX_BITS-1:0], the ghr used for the lookup, registered with the prediction.
  - Adds input upd_ghr [IDX_BITS-1:0]; update index = upd_pc index XOR upd_ghr.
  - Tag is unchanged.
- Undefined: plain PC indexing, no ghr, no pred_ghr/upd_ghr ports.

Test Plan:
- Reset INIT timing: pulse rst, then hold low. ready rises exactly 64 cycles after rst falls. A lookup at cycle 10 gives pred_valid=1, hit=0, taken=0, target=lk_pc+4.
- Allocate then predict: in RUN, upd pc=0x00400010, taken=1, target=0x00400100. Next-cycle lookup of 0x00400010 gives hit=1, taken=1, target=0x00400100.
- Saturation: after allocate, 3 not-taken updates take cnt 10->01->00->00. Lookup gives taken=0, target=0x00400014. Two taken updates return cnt to 10 (taken=1).
- Alias/tag miss: allocate 0x00400010, then look up 0x00400410 (same index 4, different tag). Result is hit=0, target=0x00400414. A taken update to 0x00400410 evicts the first entry.
- Bypass and reset mid-run: lookup and taken update of the same new PC in one cycle gives hit=1 next cycle. rst during RUN drops ready; all earlier entries read hit=0 after INIT completes.
- BP_GSHARE_EN: two PCs sharing an index but trained under ghr=0 and ghr=1 predict independently. pred_ghr matches the ghr value at lookup time.
